fifo_wr_arbiter: RTL and testbench

//   Round-robin, burst-based write arbiter sharing one async_fifo write port (wr_clk domain)

---
 rtl/fifo_wr_arbiter_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_rr.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter and the rd-side deframer.
// FSM encodings, header field layout and the channel-index width helper.
package fifo_wr_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  // Header word: flag at bit DW, seq in [11:4], channel id in [3:0].
  localparam int ID_LSB  = 0;
  localparam int ID_W    = 4;
  localparam int SEQ_LSB = 4;
  localparam int SEQ_W   = 8;

  typedef logic [SEQ_W-1:0] seq_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Rotate-priority picker: first set req searching upward from last_ptr+1.
// Ports: req[N], last_ptr -> gnt_valid, gnt_idx (purely combinational).
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = last_ptr;
    for (int k = 0; k < N; k++) begin
      idx = (idx == W'(N - 1)) ? '0 : idx + W'(1);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_CH sources.
// Ports: enable, ch_mask/valid/data/last in, ch_ready out; fifo_din/wr_en out,
// fifo_full in; busy, grant_ch, stall_cnt status outputs.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DW        = 32,
  parameter int BURST_LEN = 64,
  parameter int TIMEOUT   = 16,
  localparam int CH_W     = ch_w(N_CH)
) (
  input  logic               wr_clk,
  input  logic               wr_rst_n,
  input  logic               enable,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [N_CH-1:0]    ch_valid,
  input  logic [N_CH*DW-1:0] ch_data,
  input  logic [N_CH-1:0]    ch_last,
  output logic [N_CH-1:0]    ch_ready,
  output logic [DW:0]        fifo_din,
  output logic               fifo_wr_en,
  input  logic               fifo_full,
  output logic               busy,
  output logic [CH_W-1:0]    grant_ch,
  output logic [15:0]        stall_cnt
);

  logic [1:0]      state;
  logic [CH_W-1:0] rr_ptr;
  seq_t            seq [N_CH];
  logic [15:0]     word_cnt;
  logic [15:0]     idle_cnt;

  logic [DW-1:0]   data_arr [N_CH];
  logic [DW-1:0]   g_data;
  logic            g_valid;
  logic            g_last;
  logic            gnt_valid;
  logic [CH_W-1:0] gnt_idx;

  logic in_hdr;
  logic in_burst;
  logic hdr_wr;
  logic accept;
  logic idle_cyc;
  logic len_done;
  logic to_done;
  logic burst_end;
  logic stall_ev;

  rr_arbiter #(
    .N (N_CH),
    .W (CH_W)
  ) u_rr (
    .req       (ch_valid & ch_mask),
    .last_ptr  (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      data_arr[i] = ch_data[i*DW +: DW];
    end
  end

  assign g_data  = data_arr[grant_ch];
  assign g_valid = ch_valid[grant_ch];
  assign g_last  = ch_last[grant_ch];

  assign in_hdr   = (state == ST_HDR);
  assign in_burst = (state == ST_BURST);
  assign busy     = (state != ST_IDLE);

  assign hdr_wr   = in_hdr && !fifo_full;
  assign accept   = in_burst && g_valid && !fifo_full;
  // A full FIFO freezes the idle timer as well as the data path.
  assign idle_cyc = in_burst && !g_valid && !fifo_full;
  assign len_done = (word_cnt == 16'(BURST_LEN - 1));
  assign to_done  = (TIMEOUT != 0) && idle_cyc
                 && (idle_cnt == 16'(TIMEOUT - 1));
  assign burst_end = (accept && (g_last || len_done)) || to_done;
  assign stall_ev  = fifo_full && (in_hdr || (in_burst && g_valid));

  always_comb begin
    ch_ready   = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    unique case (1'b1)
      in_hdr: begin
        fifo_wr_en = !fifo_full;
        fifo_din[DW] = 1'b1;
        fifo_din[SEQ_LSB +: SEQ_W] = seq[grant_ch];
        fifo_din[ID_LSB +: ID_W] = ID_W'(grant_ch);
      end
      in_burst: begin
        ch_ready[grant_ch] = !fifo_full;
        fifo_wr_en = g_valid && !fifo_full;
        fifo_din = {1'b0, g_data};
      end
      default: ;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state     <= ST_IDLE;
      grant_ch  <= '0;
      rr_ptr    <= CH_W'(N_CH - 1);
      word_cnt  <= '0;
      idle_cnt  <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < N_CH; i++) begin
        seq[i] <= '0;
      end
    end else begin
      if (stall_ev && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      unique case (state)
        ST_IDLE: begin
          word_cnt <= '0;
          idle_cnt <= '0;
          if (enable && gnt_valid) begin
            grant_ch <= gnt_idx;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (hdr_wr) begin
            seq[grant_ch] <= seq[grant_ch] + seq_t'(1);
            state         <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (accept) begin
            word_cnt <= word_cnt + 16'd1;
            idle_cnt <= '0;
          end else if (idle_cyc) begin
            idle_cnt <= idle_cnt + 16'd1;
          end
          if (burst_end) begin
            state    <= ST_IDLE;
            rr_ptr   <= grant_ch;
            word_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: counting sources feed the DUT, a scoreboard
// queue holds every word expected on the FIFO write port in order.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int TO = 16;

  logic            wr_clk;
  logic            wr_rst_n;
  logic            enable;
  logic [N-1:0]    ch_mask;
  logic [N-1:0]    ch_valid;
  logic [N*DW-1:0] ch_data;
  logic [N-1:0]    ch_last;
  logic [N-1:0]    ch_ready;
  logic [DW:0]     fifo_din;
  logic            fifo_wr_en;
  logic            fifo_full;
  logic            busy;
  logic [1:0]      grant_ch;
  logic [15:0]     stall_cnt;

  int errors = 0;
  int checks = 0;
  int nwr = 0;

  logic [N-1:0] src_en;
  logic [15:0]  src_cnt [N];
  logic [15:0]  src_last_at [N];

  logic [DW:0]  exp_q [$];
  logic [7:0]   exp_seq [N];
  logic [15:0]  exp_cnt [N];
  logic [DW:0]  mon_exp;

  fifo_wr_arbiter #(
    .N_CH      (N),
    .DW        (DW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .wr_clk     (wr_clk),
    .wr_rst_n   (wr_rst_n),
    .enable     (enable),
    .ch_mask    (ch_mask),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_last    (ch_last),
    .ch_ready   (ch_ready),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .grant_ch   (grant_ch),
    .stall_cnt  (stall_cnt)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  always_comb begin
    ch_valid = src_en;
    ch_last  = '0;
    ch_data  = '0;
    for (int i = 0; i < N; i++) begin
      ch_data[i*DW +: DW] = {4'(i), 12'hA5C, src_cnt[i]};
      ch_last[i] = src_en[i] && (src_cnt[i] == src_last_at[i]);
    end
  end

  always @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      for (int i = 0; i < N; i++) src_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ch_valid[i] && ch_ready[i]) src_cnt[i] <= src_cnt[i] + 16'd1;
      end
    end
  end

  always @(negedge wr_clk) begin
    if (wr_rst_n) begin
      if (fifo_full) begin
        checks++;
        if (fifo_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL wr_while_full: wr_en=%b required 0", fifo_wr_en);
        end
      end
      if (fifo_wr_en === 1'b1) begin
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: din=%h required no write", fifo_din);
        end else begin
          mon_exp = exp_q.pop_front();
          if (fifo_din !== mon_exp) begin
            errors++;
            $display("FAIL fifo_word: got %h required %h", fifo_din, mon_exp);
          end
        end
      end
    end
  end

  function automatic logic [DW:0] hdr_w(int c, logic [7:0] s);
    return {1'b1, 20'h0, s, 4'(c)};
  endfunction

  function automatic logic [DW:0] dat_w(int c, logic [15:0] k);
    return {1'b0, 4'(c), 12'hA5C, k};
  endfunction

  task automatic push_hdr(int c);
    exp_q.push_back(hdr_w(c, exp_seq[c]));
    exp_seq[c] = exp_seq[c] + 8'd1;
  endtask

  task automatic push_burst(int c, int n);
    push_hdr(c);
    repeat (n) begin
      exp_q.push_back(dat_w(c, exp_cnt[c]));
      exp_cnt[c] = exp_cnt[c] + 16'd1;
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic wait_writes(int target, int budget);
    int n = 0;
    while (nwr < target && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (nwr < target) begin
      errors++;
      $display("FAIL write_timeout: writes=%0d required %0d", nwr, target);
    end
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic check_empty();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_words: pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_seq[i] = '0;
      exp_cnt[i] = '0;
    end
  endtask

  task automatic do_reset();
    src_en = '0;
    fifo_full = 1'b0;
    enable = 1'b1;
    ch_mask = '1;
    for (int i = 0; i < N; i++) src_last_at[i] = 16'hFFFF;
    wr_rst_n = 1'b0;
    clear_model();
    step(2);
    wr_rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    wr_rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, fifo_wr_en, ch_ready, grant_ch} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/wr/rdy/gnt=%b required 0",
               {busy, fifo_wr_en, ch_ready, grant_ch});
    end
    checks++;
    if (fifo_din !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_data: din=%h stall=%h required 0", fifo_din, stall_cnt);
    end
    wr_rst_n = 1'b1;
    step(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_latency();
    do_reset();
    push_burst(0, BL);
    push_hdr(0);
    src_en = 4'b0001;
    step(1);
    checks++;
    if (busy !== 1'b1 || fifo_wr_en !== 1'b1 || ch_ready !== '0) begin
      errors++;
      $display("FAIL hdr_cycle1: busy/wr/rdy=%b required 110000",
               {busy, fifo_wr_en, ch_ready});
    end
    checks++;
    if (fifo_din !== hdr_w(0, 8'd0)) begin
      errors++;
      $display("FAIL hdr_word: got %h required %h", fifo_din, hdr_w(0, 8'd0));
    end
    step(1);
    checks++;
    if (ch_ready !== 4'b0001 || fifo_din !== dat_w(0, 16'd0)) begin
      errors++;
      $display("FAIL data_cycle2: rdy=%b din=%h required 0001 %h",
               ch_ready, fifo_din, dat_w(0, 16'd0));
    end
    step(3);
    checks++;
    if (fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL data_cycle5: wr_en=%b required 1", fifo_wr_en);
    end
    step(1);
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle6: busy/wr=%b required 00", {busy, fifo_wr_en});
    end
    step(1);
    checks++;
    if (fifo_din !== hdr_w(0, 8'd1)) begin
      errors++;
      $display("FAIL hdr_seq1: got %h required %h", fifo_din, hdr_w(0, 8'd1));
    end
    src_en = '0;
    wait_idle(40);
    check_empty();
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    for (int b = 0; b < 5; b++) push_burst(b % N, BL);
    base = nwr;
    src_en = 4'b1111;
    step(30);
    src_en = '0;
    checks++;
    if (nwr - base != 25 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_throughput: writes=%0d busy=%b required 25 0",
               nwr - base, busy);
    end
    wait_idle(40);
    check_empty();
  endtask

  task automatic test_full_stall();
    int base;
    logic [15:0] s0;
    do_reset();
    push_burst(0, BL);
    base = nwr;
    src_en = 4'b0001;
    step(3);
    s0 = stall_cnt;
    fifo_full = 1'b1;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b0 || ch_ready !== '0) begin
      errors++;
      $display("FAIL full_block: wr/rdy=%b required 00000", {fifo_wr_en, ch_ready});
    end
    step(10);
    fifo_full = 1'b0;
    checks++;
    if (stall_cnt !== s0 + 16'd10) begin
      errors++;
      $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, s0 + 16'd10);
    end
    wait_writes(base + 5, 40);
    src_en = '0;
    wait_idle(40);
    check_empty();
  endtask

  task automatic test_last_timeout();
    int base;
    do_reset();
    src_last_at[1] = 16'd1;
    push_burst(1, 2);
    push_burst(2, BL);
    push_hdr(1);
    base = nwr;
    src_en = 4'b0110;
    wait_writes(base + 3, 40);
    step(1);
    checks++;
    if (grant_ch !== 2'd2) begin
      errors++;
      $display("FAIL grant_after_last: got %0d required 2", grant_ch);
    end
    wait_writes(base + 8, 40);
    step(1);
    src_en = '0;
    checks++;
    if (busy !== 1'b1 || grant_ch !== 2'd1) begin
      errors++;
      $display("FAIL regrant_ch1: busy=%b gnt=%0d required 1 1", busy, grant_ch);
    end
    step(TO);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: busy=%b required 1", busy);
    end
    step(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_close: busy=%b required 0", busy);
    end
    check_empty();
  endtask

  task automatic test_mask_enable();
    int base;
    do_reset();
    ch_mask = 4'b0101;
    push_burst(0, BL);
    base = nwr;
    src_en = 4'b1111;
    step(3);
    enable = 1'b0;
    wait_writes(base + 5, 40);
    step(5);
    checks++;
    if (busy !== 1'b0 || nwr != base + 5) begin
      errors++;
      $display("FAIL enable_off: busy=%b writes=%0d required 0 5", busy, nwr - base);
    end
    push_burst(2, BL);
    push_burst(0, BL);
    enable = 1'b1;
    wait_writes(base + 15, 60);
    src_en = '0;
    wait_idle(40);
    check_empty();
  endtask

  task automatic test_seq_wrap();
    int base;
    do_reset();
    ch_mask = 4'b1000;
    for (int b = 0; b < 257; b++) push_burst(3, BL);
    base = nwr;
    src_en = 4'b1111;
    wait_writes(base + 257 * (BL + 1), 257 * (BL + 2) + 50);
    src_en = '0;
    wait_idle(40);
    check_empty();
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    push_burst(1, 1);
    src_en = 4'b0010;
    step(3);
    wr_rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, fifo_wr_en, ch_ready, grant_ch} !== '0 || fifo_din !== '0) begin
      errors++;
      $display("FAIL async_reset: ctrl=%b din=%h required 0",
               {busy, fifo_wr_en, ch_ready, grant_ch}, fifo_din);
    end
    check_empty();
    clear_model();
    wr_rst_n = 1'b1;
    push_burst(0, BL);
    base = nwr;
    src_en = 4'b1111;
    step(1);
    checks++;
    if (grant_ch !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_after_reset: gnt=%0d busy=%b required 0 1", grant_ch, busy);
    end
    wait_writes(base + 5, 40);
    src_en = '0;
    wait_idle(40);
    check_empty();
  endtask

  initial begin
    wr_rst_n = 1'b0;
    src_en = '0;
    fifo_full = 1'b0;
    enable = 1'b0;
    ch_mask = '0;
    for (int i = 0; i < N; i++) src_last_at[i] = 16'hFFFF;
    test_reset();
    test_latency();
    test_round_robin();
    test_full_stall();
    test_last_timeout();
    test_mask_enable();
    test_seq_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
